// File: rtl/arm_pkg.sv
// Shared ARM core definitions: ALU command encodings, NZCV bit positions, field widths.
package arm_pkg;

  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned SHIFT_OP_W = 12;
  localparam int unsigned IMM24_W    = 24;
  localparam int unsigned EXE_CMD_W  = 4;
  localparam int unsigned SR_W       = 4;

  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_CMD_EOR = 4'b1000;

  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

endpackage

// File: rtl/id_exe_pipe_reg_field.sv
// One pipeline field: reset and flush clear it, freeze (en low) holds it.
module pipe_field_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: condition-failed instructions become bubbles; honours flush and freeze.
module id_exe_pipe_reg
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  cond_pass,
  input  logic                  id_valid,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
  input  logic                  imm_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [SHIFT_OP_W-1:0] shift_operand_in,
  input  logic [IMM24_W-1:0]    signed_imm24_in,
  input  logic [REG_IDX_W-1:0]  dest_in,
  input  logic [REG_IDX_W-1:0]  src1_in,
  input  logic [REG_IDX_W-1:0]  src2_in,
  input  logic [SR_W-1:0]       sr_in,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [EXE_CMD_W-1:0]  exe_cmd_out,
  output logic                  imm_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic [SHIFT_OP_W-1:0] shift_operand_out,
  output logic [IMM24_W-1:0]    signed_imm24_out,
  output logic [REG_IDX_W-1:0]  dest_out,
  output logic [REG_IDX_W-1:0]  src1_out,
  output logic [REG_IDX_W-1:0]  src2_out,
  output logic [SR_W-1:0]       sr_out,
  output logic                  valid_out,
  output logic                  carry_out,
  output logic [CNT_W-1:0]      squash_cnt,
  output logic [CNT_W-1:0]      issue_cnt
);

  logic live;
  logic load;
  logic squash;

  assign live   = id_valid & cond_pass;
  assign squash = id_valid & ~cond_pass;
  assign load   = ~flush & ~freeze;

  pipe_field_reg #(.WIDTH(DATA_W)) u_pc (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(pc_in), .q(pc_out));
  pipe_field_reg #(.WIDTH(DATA_W)) u_val_rn (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(val_rn_in), .q(val_rn_out));
  pipe_field_reg #(.WIDTH(DATA_W)) u_val_rm (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(val_rm_in), .q(val_rm_out));
  pipe_field_reg #(.WIDTH(SHIFT_OP_W)) u_shift_operand (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(shift_operand_in),
    .q(shift_operand_out));
  pipe_field_reg #(.WIDTH(IMM24_W)) u_signed_imm24 (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(signed_imm24_in),
    .q(signed_imm24_out));
  pipe_field_reg #(.WIDTH(REG_IDX_W)) u_dest (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(dest_in), .q(dest_out));
  pipe_field_reg #(.WIDTH(REG_IDX_W)) u_src1 (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(src1_in), .q(src1_out));
  pipe_field_reg #(.WIDTH(REG_IDX_W)) u_src2 (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(src2_in), .q(src2_out));
  pipe_field_reg #(.WIDTH(SR_W)) u_sr (
    .clk(clk), .rst(rst), .clr(flush), .en(~freeze), .d(sr_in), .q(sr_out));

  // Control bits are masked by liveness so a failed condition loads as a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      b_out        <= 1'b0;
      s_out        <= 1'b0;
      exe_cmd_out  <= '0;
      imm_out      <= 1'b0;
      valid_out    <= 1'b0;
      carry_out    <= 1'b0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in & live;
      mem_r_en_out <= mem_r_en_in & live;
      mem_w_en_out <= mem_w_en_in & live;
      b_out        <= b_in & live;
      s_out        <= s_in & live;
      exe_cmd_out  <= exe_cmd_in;
      imm_out      <= imm_in;
      valid_out    <= live;
      carry_out    <= sr_in[SR_C];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt  <= '0;
      squash_cnt <= '0;
    end else if (load) begin
      if (live)   issue_cnt  <= issue_cnt + 1'b1;
      if (squash) squash_cnt <= squash_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Randomized scoreboard bench for id_exe_pipe_reg against a behavioural reference model.
module tb_id_exe_pipe_reg;

  typedef struct packed {
    logic        rst, flush, freeze, cond_pass, id_valid;
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic        imm;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] i24;
    logic [3:0]  dest, s1, s2, sr;
  } stim_t;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic        imm;
    logic        valid, carry;
    logic [3:0]  sr;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] i24;
    logic [3:0]  dest, s1, s2;
  } data_t;

  typedef struct packed {
    ctrl_t       c;
    data_t       d;
    logic [15:0] sq, iss;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, freeze, cond_pass, id_valid;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic        valid_out, carry_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [15:0] squash_cnt, issue_cnt;

  id_exe_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .cond_pass(cond_pass),
    .id_valid(id_valid), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .imm_in(imm_in), .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .imm_out(imm_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
    .valid_out(valid_out), .carry_out(carry_out),
    .squash_cnt(squash_cnt), .issue_cnt(issue_cnt));

  int unsigned checks = 0;
  int unsigned failures = 0;
  exp_t        expq[$];
  exp_t        model;
  int unsigned n_issue, n_squash;

  // Reference: a pipeline slot holding what EXE should see, plus two event tallies.
  function automatic exp_t next_state(exp_t cur, stim_t s);
    exp_t n;
    bit   go;
    n = cur;
    if (s.rst) begin
      n = '0;
      n_issue = 0;
      n_squash = 0;
    end else if (s.flush) begin
      n.c = '0;
      n.d = '0;
    end else if (!s.freeze) begin
      go = s.id_valid && s.cond_pass;
      n.d = '{pc: s.pc, rn: s.rn, rm: s.rm, sh: s.sh, i24: s.i24,
              dest: s.dest, s1: s.s1, s2: s.s2};
      n.c.wb    = go ? s.wb : 1'b0;
      n.c.mr    = go ? s.mr : 1'b0;
      n.c.mw    = go ? s.mw : 1'b0;
      n.c.b     = go ? s.b  : 1'b0;
      n.c.s     = go ? s.s  : 1'b0;
      n.c.cmd   = s.cmd;
      n.c.imm   = s.imm;
      n.c.valid = go;
      n.c.carry = s.sr[1];
      n.c.sr    = s.sr;
      if (go) n_issue++;
      if (s.id_valid && !s.cond_pass) n_squash++;
    end
    n.iss = 16'(n_issue % 65536);
    n.sq  = 16'(n_squash % 65536);
    return n;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(stim_t s);
    {rst, flush, freeze, cond_pass, id_valid} = {s.rst, s.flush, s.freeze, s.cond_pass, s.id_valid};
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = {s.wb, s.mr, s.mw, s.b, s.s};
    exe_cmd_in = s.cmd; imm_in = s.imm; pc_in = s.pc; val_rn_in = s.rn; val_rm_in = s.rm;
    shift_operand_in = s.sh; signed_imm24_in = s.i24;
    dest_in = s.dest; src1_in = s.s1; src2_in = s.s2; sr_in = s.sr;
    model = next_state(model, s);
    expq.push_back(model);
    @(posedge clk);
    #2;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s.rst    = ($urandom_range(0, 31) == 0);
    s.flush  = ($urandom_range(0, 7) == 0);
    s.freeze = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = rand_stim();
    {s.rst, s.flush, s.freeze} = 3'b000;
    return s;
  endfunction

  // Monitor: every edge the DUT presents a new slot; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("ctrl", 256'({wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                            exe_cmd_out, imm_out, valid_out, carry_out, sr_out}), 256'(e.c));
        check("data", 256'({pc_out, val_rn_out, val_rm_out, shift_operand_out,
                            signed_imm24_out, dest_out, src1_out, src2_out}), 256'(e.d));
        check("squash_cnt", 256'(squash_cnt), 256'(e.sq));
        check("issue_cnt", 256'(issue_cnt), 256'(e.iss));
      end
    end
  end

  initial begin
    stim_t s;
    model = '0;
    n_issue = 0;
    n_squash = 0;
    #2;
    // Reset for two cycles with every input non-zero.
    for (int i = 0; i < 2; i++) begin
      s = '1;
      s.rst = 1'b1;
      step(s);
    end
    // Live load.
    s = '0; s.id_valid = 1; s.cond_pass = 1; s.wb = 1; s.cmd = 4'b0010;
    s.rn = 32'h5; s.dest = 4'd3;
    step(s);
    // Condition fail.
    s = '0; s.id_valid = 1; s.mw = 1; s.b = 1; s.rm = 32'hDEAD_BEEF;
    step(s);
    // Freeze holds for three cycles, then release loads.
    s = quiet(); s.pc = 32'h40; step(s);
    for (int i = 0; i < 3; i++) begin
      s = quiet(); s.freeze = 1; s.pc = 32'h44; step(s);
    end
    s = quiet(); s.pc = 32'h44; step(s);
    // Flush beats freeze.
    s = quiet(); s.flush = 1; s.freeze = 1; s.id_valid = 1; s.cond_pass = 1; s.sr = 4'b0010;
    step(s);
    // Reset during freeze and during flush.
    s = quiet(); s.rst = 1; s.freeze = 1; step(s);
    s = quiet(); step(s);
    s = quiet(); s.rst = 1; s.flush = 1; step(s);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s = rand_stim();
      step(s);
    end
    // Counter wrap: 65535 live loads from reset, then one more.
    s = quiet(); s.rst = 1; step(s);
    for (int i = 0; i < 65536; i++) begin
      s = quiet(); s.id_valid = 1; s.cond_pass = 1;
      step(s);
    end
    @(posedge clk);
    #3;
    check("scoreboard_drained", 256'(expq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

Pipeline register between the Decode (ID) and Execute (EXE) stages of the 32-bit ARM core. It captures decoded operands, control bits and the current NZCV status each cycle. Any instruction whose condition code fails, as reported by the condition checker, is converted into a bubble. It also honours stall (freeze) and branch flush from the hazard and branch logic, and keeps two debug counters.

## Interface
Parameters:
- DATA_W, 32, datapath width (PC, Rn, Rm values)
- CNT_W, 16, width of debug counters

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch taken in EXE; squash the instruction entering EXE
- freeze  in  1  hazard stall; hold all outputs
- cond_pass  in  1  condition-check result for the instruction in ID
- id_valid  in  1  ID holds a real instruction
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  decoded control bits
- exe_cmd_in  in  4  ALU command
- imm_in  in  1  I bit
- pc_in  in  DATA_W  PC+4 of the instruction
- val_rn_in, val_rm_in  in  DATA_W  register-file read data
- shift_operand_in  in  12  operand-2 field
- signed_imm24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  4 each  register numbers
- sr_in  in  4  NZCV {N,Z,C,V} at bits {3,2,1,0}
- Each *_in above has a registered *_out of the same width; plus:
- valid_out  out  1  EXE holds a live instruction
- carry_out  out  1  registered sr_in[1], used as ALU carry-in
- squash_cnt  out  CNT_W  instructions dropped by cond_pass=0
- issue_cnt  out  CNT_W  instructions passed to EXE live

## Operation
- Next-state priority per cycle: rst > flush > freeze > load.
- rst: every output register is set to 0, including both counters.
- flush: all control outputs, valid_out and carry_out go to 0. Data outputs go to 0. Counters are unchanged.
- freeze (no flush): all outputs hold their values. Counters are unchanged.
- Load: let live = id_valid & cond_pass.
  - All data fields, dest/src fields, exe_cmd_out, imm_out and carry_out capture their inputs unconditionally.
  - wb_en, mem_r_en, mem_w_en, b and s are captured as input & live.
  - valid_out is set to live.
- Counter rules, applied on load only:
  - issue_cnt +1 if live.
  - squash_cnt +1 if id_valid & ~cond_pass.
  - Both counters wrap modulo 2^CNT_W without saturation.
- cond_pass=0 with id_valid=0: bubble, and neither counter increments.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on the outputs after edge k.
- No combinational path from any input to any output.
- A freeze asserted on consecutive cycles holds the outputs indefinitely. Release resumes loading on the first edge with freeze=0.
- flush and freeze both high: flush wins, and the bubble is inserted on that edge.
- rst asserted during a freeze or flush: outputs are all 0 after the edge.
- Counter wrap: with issue_cnt = 2^CNT_W-1, a live load produces 0.

## Structure
- A shared package `arm_pkg` holds:
  - EXE_CMD_* constants: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000.
  - NZCV bit index constants: N=3, Z=2, C=1, V=0.
  - Field widths: REG_IDX_W=4, SHIFT_OP_W=12, IMM24_W=24.
- Sub-module `pipe_field_reg`: a parameterized WIDTH register with rst, clr (flush) and en (~freeze). It is instantiated once per data field.
- Control gating and the counters live in the top module.

## Test plan
- Reset: drive rst=1 for 2 cycles with all inputs non-zero -> every output, squash_cnt and issue_cnt = 0.
- Live load: id_valid=1, cond_pass=1, wb_en_in=1, exe_cmd_in=0010, val_rn_in=0x0000_0005, dest_in=3 -> after one edge: wb_en_out=1, exe_cmd_out=0010, val_rn_out=5, dest_out=3, valid_out=1, issue_cnt=1.
- Condition fail: id_valid=1, cond_pass=0, mem_w_en_in=1, b_in=1, val_rm_in=0xDEAD_BEEF -> mem_w_en_out=0, b_out=0, valid_out=0, val_rm_out=0xDEAD_BEEF, squash_cnt=1, issue_cnt unchanged.
- Freeze: load pc_in=0x40, then freeze=1 for 3 cycles with pc_in=0x44 -> pc_out stays 0x40 and counters are frozen. Release -> pc_out=0x44 on the next edge.
- Flush beats freeze: flush=1, freeze=1, id_valid=1, cond_pass=1, sr_in=0010 -> valid_out=0, carry_out=0, all controls 0, counters unchanged.
- Counter wrap: preload issue_cnt to 0xFFFF with CNT_W=16 via 65535 live loads (or force), then one more live load -> issue_cnt=0x0000.
